hack_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the Hack CPU core.
- Owns the program counter, issues reads to instruction ROM, and buffers returned words in a small prefetch FIFO.
- Presents one instruction at a time to the core and redirects on a taken jump (loadPC / addressI from the core).
- ROM may have variable latency; at most one ROM request is outstanding.

---
 rtl/hack_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_hack_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_fetch_unit.sv
// Hack CPU fetch stage: PC, single-outstanding ROM reads, prefetch FIFO.
// Optional perf counters are enabled by defining HACK_FETCH_PERF_EN.
module hack_fetch_unit #(
  parameter int ADDR_W = 15,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [15:0]       rom_data,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              loadPC,
  input  logic [ADDR_W-1:0] addressI
`ifdef HACK_FETCH_PERF_EN
  ,
  output logic [15:0]       redirect_count,
  output logic [15:0]       bubble_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       word;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  state_t            state;
  state_t            state_nxt;
  logic              redirect;
  logic              pop;
  logic              push;
  logic              resp;
  logic              issue;

  assign instr_valid = (count != '0);
  assign instruction = mem[rd_ptr].word;
  assign instr_pc    = mem[rd_ptr].pc;
  assign rom_req     = issue;
  assign rom_addr    = fetch_pc;

  // Handshake decode, issue decision and next state.
  always_comb begin
    redirect  = instr_valid && instr_ready && loadPC;
    pop       = instr_valid && instr_ready && !loadPC;
    resp      = (state == WAIT) && rom_valid;
    push      = resp && !redirect;
    count_nxt = count + CW'(push) - CW'(pop);
    issue     = reset_n && !redirect &&
                ((state == IDLE) || resp) &&
                (count_nxt < CW'(DEPTH));
    state_nxt = state;
    if (redirect) begin
      // A request still in flight becomes stale.
      if ((state != IDLE) && !rom_valid)
        state_nxt = DROP;
      else
        state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = issue ? WAIT : IDLE;
        WAIT: if (rom_valid)
                state_nxt = issue ? WAIT : IDLE;
        DROP: if (rom_valid)
                state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Program counter and address of the outstanding request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= addressI;
    end else if (issue) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // Prefetch FIFO; a redirect flushes it, head included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: req_pc, word: rom_data};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

`ifdef HACK_FETCH_PERF_EN
  // Saturating redirect and bubble counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_count <= '0;
      bubble_count   <= '0;
    end else begin
      if (redirect && (redirect_count != 16'hFFFF))
        redirect_count <= redirect_count + 16'd1;
      if (instr_ready && !instr_valid &&
          (bubble_count != 16'hFFFF))
        bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Bench for hack_fetch_unit: ROM and core models with a program-order
// scoreboard; also exercises HACK_FETCH_PERF_EN when it is defined.
module tb_hack_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_valid = 1'b0;
  logic [15:0] rom_data = '0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [14:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        loadPC = 1'b0;
  logic [14:0] addressI = '0;
`ifdef HACK_FETCH_PERF_EN
  logic [15:0] redirect_count;
  logic [15:0] bubble_count;
`endif

  always #5 clk = ~clk;

  hack_fetch_unit dut (
    .clk(clk),
    .reset_n(reset_n),
    .rom_req(rom_req),
    .rom_addr(rom_addr),
    .rom_valid(rom_valid),
    .rom_data(rom_data),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .loadPC(loadPC),
    .addressI(addressI)
`ifdef HACK_FETCH_PERF_EN
    ,
    .redirect_count(redirect_count),
    .bubble_count(bubble_count)
`endif
  );

  int checks = 0;
  int passed = 0;

  logic [14:0] exp_pc;
  logic [14:0] exp_ra;
  logic [14:0] pend_addr;
  bit          pend;
  int          pend_left;
  int          lat;
  bit          mute;
  bit          ghost;
  int          starve;
  int          nred;

  bit          s_req;
  bit          s_valid;
  logic [14:0] s_addr;
  logic [14:0] s_pc;
  logic [15:0] s_instr;

  function automatic logic [15:0] word(input logic [14:0] a);
    return {1'b0, a};
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One clock: drive at negedge, sample 1 time unit later.
  task automatic step(input bit rdy, input bit ld, input int ld_pc,
                      input logic [14:0] tgt);
    bit red;
    bit pp;
    @(negedge clk);
    rom_valid = 1'b0;
    rom_data  = '0;
    if (ghost) begin
      rom_valid = 1'b1;
      rom_data  = 16'hBEEF;
      ghost     = 1'b0;
    end else if (pend && !mute) begin
      pend_left--;
      if (pend_left == 0) begin
        rom_valid = 1'b1;
        rom_data  = word(pend_addr);
        pend      = 1'b0;
      end
    end
    instr_ready = rdy;
    loadPC = ld || (ld_pc >= 0 && instr_valid &&
                    instr_pc == ld_pc[14:0]);
    addressI = tgt;
    #1;
    s_req   = rom_req;
    s_valid = instr_valid;
    s_addr  = rom_addr;
    s_pc    = instr_pc;
    s_instr = instruction;
    red = instr_valid && rdy && loadPC;
    pp  = instr_valid && rdy && !loadPC;
    if (instr_valid) begin
      chk("head_pc", instr_pc, exp_pc);
      chk("head_word", instruction, word(instr_pc));
    end
    if (rom_req) begin
      chk("one_outstanding", pend, 0);
      chk("no_req_on_redirect", red, 0);
      chk("req_addr", rom_addr, exp_ra);
      pend      = 1'b1;
      pend_addr = rom_addr;
      pend_left = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
      exp_ra    = rom_addr + 15'd1;
    end
    if (pp)
      exp_pc = exp_pc + 15'd1;
    if (red) begin
      exp_pc = tgt;
      exp_ra = tgt;
      nred++;
    end
    if (rdy && !instr_valid && !mute)
      starve++;
    else
      starve = 0;
    if (rdy && !mute)
      chk("starve_bound", starve > 30, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset_n     = 1'b0;
    instr_ready = 1'b0;
    loadPC      = 1'b0;
    rom_valid   = 1'b0;
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", rom_req, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", instr_pc, 0);
`ifdef HACK_FETCH_PERF_EN
    chk("rst_redir_cnt", redirect_count, 0);
    chk("rst_bubble_cnt", bubble_count, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    pend    = 1'b0;
    exp_pc  = '0;
    exp_ra  = '0;
    starve  = 0;
    ghost   = 1'b1;
  endtask

  initial begin
    int n0;
    bit got_req;
    bit got_val;
    int nreq;
    logic [14:0] ra [3];
    bit rdy;
    bit ld;
    logic [14:0] tgt;

    lat  = 1;
    mute = 1'b0;
    nred = 0;
    pend = 1'b0;

    // Cold start, 1-cycle ROM, continuous consumption.
    apply_reset();
    step(1, 0, -1, '0);
    chk("t1_c1_req", s_req, 1);
    chk("t1_c1_addr", s_addr, 0);
    chk("t1_c1_valid", s_valid, 0);
    step(1, 0, -1, '0);
    chk("t1_c2_valid", s_valid, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, -1, '0);
      chk("t1_stream_valid", s_valid, 1);
      chk("t1_stream_word", s_instr, i);
    end

    // Stall fills the FIFO, then drain in order.
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, -1, '0);
      if (i >= 3) begin
        chk("t2_req_stop", s_req, 0);
        chk("t2_hold_valid", s_valid, 1);
        chk("t2_hold_word", s_instr, 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, -1, '0);
      chk("t2_drain_valid", s_valid, 1);
      chk("t2_drain_word", s_instr, i);
    end

    // Redirect at pc 4 with a stale request in flight.
    lat = 3;
    apply_reset();
    n0 = nred;
    for (int i = 0; i < 80 && nred == n0; i++)
      step(1, 0, 4, 15'h0100);
    chk("t3_redirect_seen", nred - n0, 1);
    got_req = 1'b0;
    got_val = 1'b0;
    for (int i = 0; i < 30 && !got_val; i++) begin
      step(1, 0, -1, '0);
      if (s_req && !got_req) begin
        got_req = 1'b1;
        chk("t3_first_addr", s_addr, 15'h0100);
      end
      if (s_valid) begin
        got_val = 1'b1;
        chk("t3_first_pc", s_pc, 15'h0100);
      end
    end
    chk("t3_valid_seen", got_val, 1);

    // Redirect alongside rom_valid, then with a full FIFO.
    lat = 1;
    apply_reset();
    step(0, 0, -1, '0);
    step(0, 0, -1, '0);
    step(1, 1, -1, 15'h0200);
    chk("t4a_no_req", s_req, 0);
    step(0, 0, -1, '0);
    chk("t4a_req", s_req, 1);
    chk("t4a_addr", s_addr, 15'h0200);
    chk("t4a_flushed", s_valid, 0);
    step(0, 0, -1, '0);
    chk("t4a_empty", s_valid, 0);
    step(0, 0, -1, '0);
    chk("t4a_head", s_pc, 15'h0200);
    step(1, 1, -1, 15'h0300);
    chk("t4b_no_req", s_req, 0);
    step(0, 0, -1, '0);
    chk("t4b_req", s_req, 1);
    chk("t4b_addr", s_addr, 15'h0300);
    chk("t4b_flushed", s_valid, 0);

    // Address wrap, then a mid-run reset.
    apply_reset();
    n0 = nred;
    for (int i = 0; i < 20 && nred == n0; i++)
      step(1, 0, 2, 15'h7FFE);
    nreq = 0;
    for (int i = 0; i < 20 && nreq < 3; i++) begin
      step(1, 0, -1, '0);
      if (s_req) begin
        ra[nreq] = s_addr;
        nreq++;
      end
    end
    chk("t5_nreq", nreq, 3);
    chk("t5_addr0", ra[0], 15'h7FFE);
    chk("t5_addr1", ra[1], 15'h7FFF);
    chk("t5_addr2", ra[2], 15'h0000);
    for (int i = 0; i < 4; i++)
      step(1, 0, -1, '0);
    apply_reset();
    step(1, 0, -1, '0);
    chk("t5_restart_req", s_req, 1);
    chk("t5_restart_addr", s_addr, 0);

    // Random traffic with variable ROM latency.
    lat = 0;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        tgt = 15'h7FFC + 15'($urandom_range(0, 3));
      else
        tgt = 15'($urandom);
      step(rdy, ld, -1, tgt);
      if (i % 1000 == 999)
        apply_reset();
    end

`ifdef HACK_FETCH_PERF_EN
    lat = 1;
    apply_reset();
    n0 = nred;
    for (int i = 0; i < 60 && nred - n0 < 3; i++)
      step(1, 1, -1, 15'h0010);
    step(0, 0, -1, '0);
    chk("perf_redirects", redirect_count, 3);
    apply_reset();
    mute = 1'b1;
    for (int i = 0; i < 70000; i++)
      step(1, 0, -1, '0);
    chk("perf_bubble_sat", bubble_count, 16'hFFFF);
    mute = 1'b0;
    apply_reset();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
